// File: rtl/cmac_pkg.sv
// cmac_pkg: shared types and helpers for the AES-CMAC sequencer.
//   BLK_W   - AES / CMAC block width in bits
//   CMAC_RB - reduction constant for GF(2^128) doubling
//   state_e - sequencer FSM states
//   dbl()   - GF(2^128) doubling used to derive K1 and K2 from L
package cmac_pkg;

    localparam int BLK_W = 128;
    localparam logic [BLK_W-1:0] CMAC_RB = 128'h87;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SK_ISSUE = 3'd1,
        ST_SK_WAIT  = 3'd2,
        ST_FETCH    = 3'd3,
        ST_ISSUE    = 3'd4,
        ST_WAIT     = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    // Multiply by x in GF(2^128): shift left, fold the carried-out bit back with Rb.
    function automatic logic [BLK_W-1:0] dbl(input logic [BLK_W-1:0] v);
        logic [BLK_W-1:0] r;
        if (v[BLK_W-1]) begin
            r = {v[BLK_W-2:0], 1'b0} ^ CMAC_RB;
        end else begin
            r = {v[BLK_W-2:0], 1'b0};
        end
        return r;
    endfunction

endpackage

// File: rtl/cmac_sequencer_if.sv
// cmac_sequencer_if: bundles the sequencer's request, BRAM, AES-core and
// result signals.
//   master - the sequencer side (drives ram_*, aes_pt*, busy/done/err/tag)
//   slave  - the environment side (drives start/parameters, ram_rd_data, aes_ct)
interface cmac_sequencer_if
    import cmac_pkg::*;
#(
    parameter int ADDR_W = 9
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] num_blocks;
    logic              last_complete;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_en;
    logic [BLK_W-1:0]  ram_rd_data;
    logic [BLK_W-1:0]  aes_pt;
    logic              aes_pt_valid;
    logic [BLK_W-1:0]  aes_ct;
    logic              busy;
    logic              done;
    logic              err;
    logic [BLK_W-1:0]  tag;

    modport master (
        input  start, base_addr, num_blocks, last_complete, ram_rd_data, aes_ct,
        output ram_addr, ram_en, aes_pt, aes_pt_valid, busy, done, err, tag
    );

    modport slave (
        output start, base_addr, num_blocks, last_complete, ram_rd_data, aes_ct,
        input  ram_addr, ram_en, aes_pt, aes_pt_valid, busy, done, err, tag
    );

endinterface

// File: rtl/cmac_sequencer.sv
// cmac_sequencer: control FSM that time-shares one fixed-latency AES core
// between subkey generation (L = AES(0), K1 = dbl(L), K2 = dbl(K1)) and the
// CBC-MAC chain over N message blocks read from BRAM. The subkey selected by
// last_complete is folded into the final block; the resulting tag is
// published with a one-cycle done pulse.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   bus        - cmac_sequencer_if.master (request, BRAM, AES core, result)
module cmac_sequencer
    import cmac_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int AES_LAT = 14,
    parameter int RAM_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    cmac_sequencer_if.master bus
);

    localparam int MAX_LAT = (AES_LAT > RAM_LAT) ? AES_LAT : RAM_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] AES_LAST = CNT_W'(AES_LAT - 1);
    localparam logic [CNT_W-1:0] RAM_LAST = CNT_W'(RAM_LAT - 1);

    state_e            state_r, state_nxt;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] base_r, n_r, i_r, ram_addr_r;
    logic              lc_r, ram_en_r, done_r, err_r;
    logic [BLK_W-1:0]  x_r, k1_r, k2_r, tag_r;
    logic [BLK_W-1:0]  pt_mask, aes_pt_c;
    logic              aes_pt_valid_c;
    logic              is_last;

    assign is_last = (i_r == (n_r - ADDR_W'(1)));

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic; each wait state runs until its latency counter reaches the last cycle.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && (bus.num_blocks != '0)) state_nxt = ST_SK_ISSUE;
                else                                     state_nxt = ST_IDLE;
            end
            ST_SK_ISSUE: state_nxt = ST_SK_WAIT;
            ST_SK_WAIT: begin
                if (cnt_r == AES_LAST) state_nxt = ST_FETCH;
                else                   state_nxt = ST_SK_WAIT;
            end
            ST_FETCH: begin
                if (cnt_r == RAM_LAST) state_nxt = ST_ISSUE;
                else                   state_nxt = ST_FETCH;
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (cnt_r != AES_LAST) state_nxt = ST_WAIT;
                else if (is_last)      state_nxt = ST_DONE;
                else                   state_nxt = ST_FETCH;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // AES plaintext: zero for the subkey issue, chain ^ block ^ subkey-mask for block issues.
    always_comb begin
        pt_mask        = '0;
        aes_pt_c       = '0;
        aes_pt_valid_c = 1'b0;
        if (is_last) begin
            pt_mask = lc_r ? k1_r : k2_r;
        end else begin
            pt_mask = '0;
        end
        case (state_r)
            ST_SK_ISSUE: aes_pt_valid_c = 1'b1;
            ST_ISSUE: begin
                aes_pt_c       = x_r ^ bus.ram_rd_data ^ pt_mask;
                aes_pt_valid_c = 1'b1;
            end
            default: begin
                aes_pt_c       = '0;
                aes_pt_valid_c = 1'b0;
            end
        endcase
    end

    // Datapath: latency counter, latched request, subkeys, chain, BRAM address and result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r      <= '0;
            base_r     <= '0;
            n_r        <= '0;
            lc_r       <= 1'b0;
            i_r        <= '0;
            x_r        <= '0;
            k1_r       <= '0;
            k2_r       <= '0;
            tag_r      <= '0;
            ram_addr_r <= '0;
            ram_en_r   <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            // The counter restarts on every state change, so it measures cycles spent in the current state.
            cnt_r  <= (state_nxt == state_r) ? (cnt_r + CNT_W'(1)) : '0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && (bus.num_blocks == '0)) begin
                        err_r <= 1'b1;
                    end else if (bus.start) begin
                        base_r <= bus.base_addr;
                        n_r    <= bus.num_blocks;
                        lc_r   <= bus.last_complete;
                        x_r    <= '0;
                        i_r    <= '0;
                    end
                end
                ST_SK_WAIT: begin
                    if (cnt_r == AES_LAST) begin
                        k1_r       <= dbl(bus.aes_ct);
                        k2_r       <= dbl(dbl(bus.aes_ct));
                        ram_addr_r <= base_r;
                        ram_en_r   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (cnt_r == RAM_LAST) ram_en_r <= 1'b0;
                end
                ST_WAIT: begin
                    if (cnt_r == AES_LAST) begin
                        x_r <= bus.aes_ct;
                        if (is_last) begin
                            // Tag and done land together, i.e. in the DONE cycle.
                            tag_r  <= bus.aes_ct;
                            done_r <= 1'b1;
                        end else begin
                            i_r        <= i_r + ADDR_W'(1);
                            ram_addr_r <= base_r + i_r + ADDR_W'(1);
                            ram_en_r   <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ram_addr     = ram_addr_r;
    assign bus.ram_en       = ram_en_r;
    assign bus.aes_pt       = aes_pt_c;
    assign bus.aes_pt_valid = aes_pt_valid_c;
    assign bus.busy         = (state_r != ST_IDLE);
    assign bus.done         = done_r;
    assign bus.err          = err_r;
    assign bus.tag          = tag_r;

endmodule

// File: tb/tb_cmac_sequencer.sv
// Testbench for cmac_sequencer: behavioural AES-128 core and BRAM models,
// a scoreboard of expected tags/done cycles filled by the stimulus and
// drained by a done monitor, plus directed checks of reset, err and subkeys.
module tb_cmac_sequencer;

    localparam int ADDR_W  = 9;
    localparam int AES_LAT = 14;
    localparam int RAM_LAT = 1;
    localparam int RUN_LEN = RAM_LAT + 1 + AES_LAT;

    localparam logic [127:0] KEY     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_EXP  = 128'hfbeed618357133667c85e08f7236a8de;
    localparam logic [127:0] K2_EXP  = 128'hf7ddac306ae266ccf90bc11ee46d513b;
    localparam logic [127:0] MSG0    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] MSG1    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] MSG2    = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] MSG3    = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] PAD     = 128'h80000000000000000000000000000000;
    localparam logic [127:0] TAG1    = 128'h070a16b46b4d4144f79bdd9dd04a287c;
    localparam logic [127:0] TAG0    = 128'hbb1d6929e95937287fa37d129b756746;
    localparam logic [127:0] TAG4    = 128'h51f0bebf7e3b9d92fc49741779363cfe;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    logic [7:0]   sbox [256];
    logic [127:0] mem [512];
    logic [127:0] ram_q;
    logic [127:0] aes_pipe [AES_LAT];

    logic [127:0] exp_tag_q [$];
    int           exp_cyc_q [$];

    cmac_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    cmac_sequencer #(
        .ADDR_W (ADDR_W),
        .AES_LAT(AES_LAT),
        .RAM_LAT(RAM_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES-128 reference ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] rk [176];
        logic [7:0] st [16];
        logic [7:0] tmp [16];
        logic [7:0] t0, t1, t2, t3, rc;
        logic [127:0] out;
        rc = 8'h01;
        for (int k = 0; k < 16; k++) begin
            rk[k] = key[127-8*k -: 8];
            st[k] = pt[127-8*k -: 8];
        end
        for (int w = 4; w < 44; w++) begin
            t0 = rk[4*w-4]; t1 = rk[4*w-3]; t2 = rk[4*w-2]; t3 = rk[4*w-1];
            if (w % 4 == 0) begin
                {t0, t1, t2, t3} = {sbox[t1] ^ rc, sbox[t2], sbox[t3], sbox[t0]};
                rc = gmul(rc, 8'h02);
            end
            rk[4*w]   = rk[4*w-16] ^ t0;
            rk[4*w+1] = rk[4*w-15] ^ t1;
            rk[4*w+2] = rk[4*w-14] ^ t2;
            rk[4*w+3] = rk[4*w-13] ^ t3;
        end
        for (int k = 0; k < 16; k++) st[k] = st[k] ^ rk[k];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) tmp[k] = sbox[st[(((k/4) + (k%4)) % 4)*4 + (k%4)]];
            for (int c = 0; c < 4; c++) begin
                if (r != 10) begin
                    st[4*c]   = gmul(tmp[4*c], 8'h02) ^ gmul(tmp[4*c+1], 8'h03) ^ tmp[4*c+2] ^ tmp[4*c+3];
                    st[4*c+1] = tmp[4*c] ^ gmul(tmp[4*c+1], 8'h02) ^ gmul(tmp[4*c+2], 8'h03) ^ tmp[4*c+3];
                    st[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ gmul(tmp[4*c+2], 8'h02) ^ gmul(tmp[4*c+3], 8'h03);
                    st[4*c+3] = gmul(tmp[4*c], 8'h03) ^ tmp[4*c+1] ^ tmp[4*c+2] ^ gmul(tmp[4*c+3], 8'h02);
                end else begin
                    for (int j = 0; j < 4; j++) st[4*c+j] = tmp[4*c+j];
                end
            end
            for (int k = 0; k < 16; k++) st[k] = st[k] ^ rk[16*r+k];
        end
        for (int k = 0; k < 16; k++) out[127-8*k -: 8] = st[k];
        return out;
    endfunction

    // CMAC as defined mathematically: multiply by x in GF(2^128).
    function automatic logic [127:0] gf_double(input logic [127:0] v);
        return {v[126:0], 1'b0} ^ (v[127] ? 128'h87 : 128'h0);
    endfunction

    function automatic logic [127:0] ref_cmac(input logic [8:0] base, input int n, input logic lc);
        logic [127:0] l, k1, k2, x, m;
        l  = aes_enc(KEY, 128'h0);
        k1 = gf_double(l);
        k2 = gf_double(k1);
        x  = 128'h0;
        for (int b = 0; b < n; b++) begin
            m = mem[9'(int'(base) + b)];
            if (b == n - 1) m = m ^ (lc ? k1 : k2);
            x = aes_enc(KEY, x ^ m);
        end
        return x;
    endfunction

    // ---------------- external models ----------------
    always @(posedge clk) begin
        if (bus.aes_pt_valid) aes_pipe[0] <= aes_enc(KEY, bus.aes_pt);
        else                  aes_pipe[0] <= 128'h0;
        for (int k = 1; k < AES_LAT; k++) aes_pipe[k] <= aes_pipe[k-1];
    end
    assign bus.aes_ct = aes_pipe[AES_LAT-1];

    always @(posedge clk) if (bus.ram_en) ram_q <= mem[bus.ram_addr];
    assign bus.ram_rd_data = ram_q;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected run.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            checks++;
            if (exp_tag_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                logic [127:0] et;
                int           ec;
                et = exp_tag_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (bus.tag !== et) begin
                    errors++;
                    $display("FAIL tag: got %h expected %h", bus.tag, et);
                end
                chk("done_cycle", 128'(cyc), 128'(ec));
            end
        end
    end

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_tag"},      bus.tag,                128'h0);
        chk({pfx, "_busy"},     128'(bus.busy),         128'h0);
        chk({pfx, "_done"},     128'(bus.done),         128'h0);
        chk({pfx, "_err"},      128'(bus.err),          128'h0);
        chk({pfx, "_ram_en"},   128'(bus.ram_en),       128'h0);
        chk({pfx, "_ram_addr"}, 128'(bus.ram_addr),     128'h0);
        chk({pfx, "_aes_pt"},   bus.aes_pt,             128'h0);
        chk({pfx, "_pt_valid"}, 128'(bus.aes_pt_valid), 128'h0);
    endtask

    // Caller is at a negedge; start is sampled at the following posedge.
    task automatic start_run(input logic [8:0] base, input logic [8:0] n, input logic lc,
                             input logic [127:0] exp_tag);
        bus.start = 1'b1; bus.base_addr = base; bus.num_blocks = n; bus.last_complete = lc;
        exp_tag_q.push_back(exp_tag);
        exp_cyc_q.push_back(cyc + 2 + AES_LAT + int'(n) * RUN_LEN);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_rise", 128'(bus.busy), 128'h1);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_tag_q.size() != 0 || bus.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_tag_q.size() != 0 || bus.busy) begin
            errors++;
            $display("FAIL drain: got %0d pending runs busy=%0d expected 0 and idle",
                     exp_tag_q.size(), bus.busy);
            exp_tag_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: got timeout at cycle %0d expected completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] tag_hold;
        logic [8:0]   rb, rn;
        logic         rl;

        cyc = 0; checks = 0; errors = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.num_blocks = '0; bus.last_complete = 1'b0;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        for (int a = 0; a < 512; a++) mem[a] = 128'h0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // N=1 complete block, then subkeys and tag hold.
        mem[20] = MSG0;
        start_run(9'd20, 9'd1, 1'b1, TAG1);
        wait_drain(200);
        chk("k1", dut.k1_r, K1_EXP);
        chk("k2", dut.k2_r, K2_EXP);
        repeat (3) @(negedge clk);
        chk("tag_hold", bus.tag, TAG1);

        // Empty message, padded, K2.
        mem[100] = PAD;
        start_run(9'd100, 9'd1, 1'b0, TAG0);
        wait_drain(200);

        // N=4 across the address wrap, with a start pulse during WAIT that must be ignored.
        mem[510] = MSG0; mem[511] = MSG1; mem[0] = MSG2; mem[1] = MSG3;
        start_run(9'd510, 9'd4, 1'b1, TAG4);
        repeat (18) @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 9'd20; bus.num_blocks = 9'd1; bus.last_complete = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_during_wait", 128'(bus.busy), 128'h1);
        wait_drain(300);

        // num_blocks = 0: err pulse at S+1, no run, tag unchanged.
        tag_hold = bus.tag;
        bus.start = 1'b1; bus.num_blocks = 9'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("err_pulse", 128'(bus.err), 128'h1);
        chk("err_busy", 128'(bus.busy), 128'h0);
        @(negedge clk);
        chk("err_clear", 128'(bus.err), 128'h0);
        chk("err_tag", bus.tag, tag_hold);

        // Randomised runs, sometimes back-to-back with the previous run.
        for (int r = 0; r < 6; r++) begin
            rn = 9'($urandom_range(1, 5));
            rb = 9'($urandom_range(0, 511));
            rl = 1'($urandom_range(0, 1));
            for (int b = 0; b < int'(rn); b++)
                mem[9'(int'(rb) + b)] = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_run(rb, rn, rl, ref_cmac(rb, int'(rn), rl));
            wait_drain(500);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of block 2, then restart with the N=1 vector.
        mem[510] = MSG0; mem[511] = MSG1; mem[0] = MSG2; mem[1] = MSG3;
        start_run(9'd510, 9'd4, 1'b1, TAG4);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        exp_tag_q.delete();
        exp_cyc_q.delete();
        #1;
        chk_reset_outputs("midrun");
        chk("midrun_k1", dut.k1_r, 128'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_run(9'd20, 9'd1, 1'b1, TAG1);
        wait_drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
